ps2_mouse_master_ext: RTL and testbench

//  Host-side PS/2 mouse master, next generation of the mouse setup/stream controller. Drives the

---
 rtl/ps2_mouse_master_ext.sv | 144 ++++++++++++++
 tb/tb_ps2_mouse_master_ext.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_master_ext.sv
// ps2_mouse_master_ext: host-side PS/2 mouse master with init retries, watchdog and packet assembly
module ps2_mouse_master_ext #(
  parameter int STARTUP_CYCLES = 1000000,
  parameter int RESP_TIMEOUT   = 2000000,
  parameter int MAX_RETRIES    = 3,
  parameter bit WHEEL_EN       = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic [7:0] MOUSE_DZ,
  output logic       WHEEL_MODE,
  output logic       SEND_INTERRUPT,
  output logic       INIT_FAIL,
  output logic [4:0] MASTER_STATE
);
  localparam int CMAX = STARTUP_CYCLES > RESP_TIMEOUT ? STARTUP_CYCLES : RESP_TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [4:0] {WAIT_PWR = 5'd0, TX = 5'd1, RX = 5'd2, STREAM = 5'd3, FAIL = 5'h1F} state_t;
  state_t state, state_n;
  logic [4:0] step, step_n, step_adv;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] att, att_n;
  logic [1:0] idx;
  logic [7:0] sh0, sh1, sh2, tx_q, op_b;
  logic [9:0] op_nx;
  logic op_tx, op_id, rx_ok, rx_val, to_resp, last, fail;
  // init script entry: {is_tx, is_id_reply, byte}; unlisted steps expect an FA ack
  function automatic logic [9:0] op(input logic [4:0] s);
    case (s)
      5'd0:                op = {2'b10, 8'hFF};
      5'd2:                op = {2'b00, 8'hAA};
      5'd3:                op = {2'b00, 8'h00};
      5'd4, 5'd8, 5'd12:   op = {2'b10, 8'hF3};
      5'd6:                op = {2'b10, 8'hC8};
      5'd10:               op = {2'b10, 8'h64};
      5'd14:               op = {2'b10, 8'h50};
      5'd16:               op = {2'b10, 8'hF2};
      5'd18:               op = {2'b01, 8'h00};
      5'd19:               op = {2'b10, 8'hF4};
      default:             op = {2'b00, 8'hFA};
    endcase
  endfunction
  assign {op_tx, op_id, op_b} = op(step);
  assign step_adv = (step == 5'd3 && !WHEEL_EN) ? 5'd19 : step + 5'd1;
  assign op_nx = op(step_adv);
  assign to_resp = cnt == CW'(RESP_TIMEOUT);
  assign rx_ok = BYTE_READY && BYTE_ERROR_CODE == 2'b00;
  assign rx_val = op_id ? (BYTE_READ == 8'h03 || BYTE_READ == 8'h00) : BYTE_READ == op_b;
  assign last = idx == (WHEEL_MODE ? 2'd3 : 2'd2);
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= WAIT_PWR;
      step  <= '0;
      cnt   <= '0;
      att   <= '0;
    end else begin
      state <= state_n;
      step  <= step_n;
      cnt   <= cnt_n;
      att   <= att_n;
    end
  end
  always_comb begin
    state_n = state;
    step_n = step;
    att_n = att;
    fail = 1'b0;
    if (state == WAIT_PWR) begin
      if (cnt == CW'(STARTUP_CYCLES)) begin
        state_n = TX;
        step_n = '0;
      end
    end else if (state == TX || state == RX) begin
      if (state == TX ? BYTE_SENT : BYTE_READY) begin
        if (state == TX || (rx_ok && rx_val)) begin
          step_n = step_adv;
          state_n = step == 5'd20 ? STREAM : op_nx[9] ? TX : RX;
          att_n = step == 5'd20 ? 4'd0 : att;
        end else fail = 1'b1;
      end else if (to_resp) fail = 1'b1;
    end else if (state == STREAM && BYTE_READY && BYTE_ERROR_CODE != 2'b00) begin
      state_n = WAIT_PWR;
      att_n = '0;
    end
    if (fail) begin
      att_n = att + 4'd1;
      state_n = att + 4'd1 == 4'(MAX_RETRIES) ? FAIL : WAIT_PWR;
    end
    // watchdog restarts on every transition; in STREAM it only runs mid-packet
    cnt_n = (state_n != state || step_n != step) ? '0 :
            state == FAIL ? cnt :
            (state == STREAM && (idx == 2'd0 || BYTE_READY || to_resp)) ? '0 : cnt + 1'b1;
  end
  always_comb begin
    SEND_BYTE = state == TX && cnt == '0;
    BYTE_TO_SEND = state == TX ? op_b : tx_q;
    READ_ENABLE = state == RX || state == STREAM;
    INIT_FAIL = state == FAIL;
    MASTER_STATE = state;
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      {sh0, sh1, sh2, tx_q} <= '0;
      {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ} <= '0;
      idx <= '0;
      WHEEL_MODE <= 1'b0;
      SEND_INTERRUPT <= 1'b0;
    end else begin
      SEND_INTERRUPT <= 1'b0;
      if (state == TX) tx_q <= op_b;
      if (state == RX && op_id && rx_ok && rx_val) WHEEL_MODE <= BYTE_READ == 8'h03;
      if (state != STREAM) idx <= '0;
      else if (rx_ok) begin
        if (idx == 2'd0) begin
          if (BYTE_READ[3]) begin
            sh0 <= BYTE_READ;
            idx <= 2'd1;
          end
        end else if (last) begin
          MOUSE_STATUS <= sh0;
          MOUSE_DX <= sh1;
          MOUSE_DY <= WHEEL_MODE ? sh2 : BYTE_READ;
          MOUSE_DZ <= WHEEL_MODE ? BYTE_READ : 8'h00;
          SEND_INTERRUPT <= 1'b1;
          idx <= '0;
        end else begin
          if (idx == 2'd1) sh1 <= BYTE_READ;
          else sh2 <= BYTE_READ;
          idx <= idx + 2'd1;
        end
      end else if (BYTE_READY || (idx != 2'd0 && to_resp)) idx <= '0;
    end
  end
endmodule

// File: tb/tb_ps2_mouse_master_ext.sv
// tb_ps2_mouse_master_ext: table-driven check of init sequencing, stream assembly, resync and retry limits
module tb_ps2_mouse_master_ext;
  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       SEND_BYTE, BYTE_SENT = 1'b0, READ_ENABLE, BYTE_READY = 1'b0;
  logic [7:0] BYTE_TO_SEND, BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ;
  logic       WHEEL_MODE, SEND_INTERRUPT, INIT_FAIL;
  logic [4:0] MASTER_STATE;
  int nvec = 0, nerr = 0, n_int = 0, n_send = 0;

  ps2_mouse_master_ext #(.STARTUP_CYCLES(20), .RESP_TIMEOUT(100), .MAX_RETRIES(3), .WHEEL_EN(1'b1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
    .BYTE_SENT(BYTE_SENT), .READ_ENABLE(READ_ENABLE), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .BYTE_READY(BYTE_READY), .MOUSE_STATUS(MOUSE_STATUS),
    .MOUSE_DX(MOUSE_DX), .MOUSE_DY(MOUSE_DY), .MOUSE_DZ(MOUSE_DZ), .WHEEL_MODE(WHEEL_MODE),
    .SEND_INTERRUPT(SEND_INTERRUPT), .INIT_FAIL(INIT_FAIL), .MASTER_STATE(MASTER_STATE));

  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    if (SEND_INTERRUPT) n_int++;
    if (SEND_BYTE) n_send++;
  end

  typedef struct { logic tx; logic [7:0] b; } init_t;
  typedef struct { int gap; logic [7:0] b; logic [1:0] code; logic intr; logic [31:0] regs; } sv_t;
  init_t iv[21];
  sv_t s1[4];
  sv_t s2[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_send(input int bound);
    for (int i = 0; i < bound && !SEND_BYTE; i++) @(negedge CLK);
    chk("send_seen", {31'd0, SEND_BYTE}, 32'd1);
  endtask

  task automatic pulse_sent();
    @(negedge CLK) BYTE_SENT = 1'b1;
    @(negedge CLK) BYTE_SENT = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b, input logic [1:0] code);
    @(negedge CLK);
    BYTE_READ = b;
    BYTE_ERROR_CODE = code;
    BYTE_READY = 1'b1;
    @(negedge CLK);
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic run_init(input logic [7:0] id);
    iv[18].b = id;
    foreach (iv[i]) begin
      if (iv[i].tx) begin
        wait_send(200);
        chk($sformatf("tx_byte[%0d]", i), {24'd0, BYTE_TO_SEND}, {24'd0, iv[i].b});
        pulse_sent();
      end else begin
        chk($sformatf("rx_en[%0d]", i), {31'd0, READ_ENABLE}, 32'd1);
        rx(iv[i].b, 2'b00);
      end
    end
  endtask

  task automatic run_stream(input sv_t v, input string nm);
    repeat (v.gap) @(negedge CLK);
    rx(v.b, v.code);
    chk({nm, "_int"}, {31'd0, SEND_INTERRUPT}, {31'd0, v.intr});
    chk({nm, "_regs"}, {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ}, v.regs);
  endtask

  initial begin
    int base;
    iv = '{'{1'b1, 8'hFF}, '{1'b0, 8'hFA}, '{1'b0, 8'hAA}, '{1'b0, 8'h00},
           '{1'b1, 8'hF3}, '{1'b0, 8'hFA}, '{1'b1, 8'hC8}, '{1'b0, 8'hFA},
           '{1'b1, 8'hF3}, '{1'b0, 8'hFA}, '{1'b1, 8'h64}, '{1'b0, 8'hFA},
           '{1'b1, 8'hF3}, '{1'b0, 8'hFA}, '{1'b1, 8'h50}, '{1'b0, 8'hFA},
           '{1'b1, 8'hF2}, '{1'b0, 8'hFA}, '{1'b0, 8'h03}, '{1'b1, 8'hF4}, '{1'b0, 8'hFA}};
    s1 = '{'{0, 8'h08, 2'b00, 1'b0, 32'h0}, '{0, 8'h05, 2'b00, 1'b0, 32'h0},
           '{0, 8'hFB, 2'b00, 1'b0, 32'h0}, '{0, 8'hFF, 2'b00, 1'b1, 32'h0805FBFF}};
    s2 = '{'{0, 8'h09, 2'b00, 1'b0, 32'h0805FBFF}, '{0, 8'h01, 2'b00, 1'b0, 32'h0805FBFF},
           '{0, 8'h02, 2'b00, 1'b1, 32'h09010200},
           '{0, 8'h00, 2'b00, 1'b0, 32'h09010200}, '{0, 8'h08, 2'b00, 1'b0, 32'h09010200},
           '{0, 8'h10, 2'b00, 1'b0, 32'h09010200}, '{0, 8'h20, 2'b00, 1'b1, 32'h08102000},
           '{0, 8'h08, 2'b00, 1'b0, 32'h08102000}, '{0, 8'h10, 2'b00, 1'b0, 32'h08102000},
           '{150, 8'h18, 2'b00, 1'b0, 32'h08102000}, '{0, 8'h01, 2'b00, 1'b0, 32'h08102000},
           '{0, 8'h02, 2'b00, 1'b1, 32'h18010200}};
    repeat (3) @(negedge CLK);
    chk("rst_ctl", {27'd0, SEND_BYTE, READ_ENABLE, WHEEL_MODE, SEND_INTERRUPT, INIT_FAIL}, 32'd0);
    chk("rst_state", {27'd0, MASTER_STATE}, 32'd0);
    chk("rst_regs", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ}, 32'd0);
    chk("rst_tx", {24'd0, BYTE_TO_SEND}, 32'd0);
    RESET_N = 1'b1;
    chk("wait_pwr_no_rx", {31'd0, READ_ENABLE}, 32'd0);
    // wheel-enabled init, mouse answers ID 03
    run_init(8'h03);
    chk("wheel_on", {31'd0, WHEEL_MODE}, 32'd1);
    chk("stream_rx_en", {31'd0, READ_ENABLE}, 32'd1);
    base = n_int;
    foreach (s1[i]) run_stream(s1[i], $sformatf("s1[%0d]", i));
    @(negedge CLK);
    chk("s1_int_count", n_int - base, 32'd1);
    // receive error mid-packet forces full re-init; ID 00 this time
    rx(8'h08, 2'b00);
    rx(8'h05, 2'b01);
    chk("err_rx_drop", {31'd0, READ_ENABLE}, 32'd0);
    chk("err_state", {27'd0, MASTER_STATE}, 32'd0);
    chk("err_regs_hold", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY, MOUSE_DZ}, 32'h0805FBFF);
    run_init(8'h00);
    chk("wheel_off", {31'd0, WHEEL_MODE}, 32'd0);
    base = n_int;
    foreach (s2[i]) run_stream(s2[i], $sformatf("s2[%0d]", i));
    @(negedge CLK);
    chk("s2_int_count", n_int - base, 32'd3);
    // silent mouse: three FF attempts then sticky fail
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    base = n_send;
    for (int a = 0; a < 3; a++) begin
      wait_send(300);
      chk($sformatf("retry_ff[%0d]", a), {24'd0, BYTE_TO_SEND}, 32'h000000FF);
      pulse_sent();
    end
    for (int i = 0; i < 300 && !INIT_FAIL; i++) @(negedge CLK);
    chk("init_fail", {31'd0, INIT_FAIL}, 32'd1);
    chk("fail_state", {27'd0, MASTER_STATE}, 32'h1F);
    repeat (500) @(negedge CLK);
    chk("fail_sends", n_send - base, 32'd3);
    chk("fail_sticky", {30'd0, INIT_FAIL, READ_ENABLE}, 32'd2);
    // reset asserted while a command is being transmitted
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    chk("rst_clears_fail", {31'd0, INIT_FAIL}, 32'd0);
    wait_send(200);
    RESET_N = 1'b0;
    #1;
    chk("midtx_rst_ctl", {27'd0, SEND_BYTE, READ_ENABLE, WHEEL_MODE, SEND_INTERRUPT, INIT_FAIL}, 32'd0);
    chk("midtx_rst_tx", {19'd0, BYTE_TO_SEND, MASTER_STATE}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
